// File: rtl/seq_gen.sv
`default_nettype none
// ============================================================================
//  Module      : seq_gen
//  Description : Serial sequence generator, the transmit end of the serial
//                pattern link. Holds a WIDTH-bit pattern and shifts it out
//                MSB-first, one bit per clock, back-to-back for a programmed
//                number of repetitions (0 = continuous until stopped).
//  Ports       : clk        - single clock, rising edge
//                reset      - asynchronous, active-high, clears all state
//                load_i     - load pattern_i into the pattern register (IDLE)
//                pattern_i  - new pattern value
//                start_i    - begin transmission (IDLE only)
//                reps_i     - repetitions sampled with start_i, 0 = continuous
//                stop_i     - graceful stop at the next pattern boundary
//                x_o        - serial data, 0 when valid_o is low
//                valid_o    - x_o carries a pattern bit
//                frame_o    - first (MSB) bit of each pattern instance
//                busy_o     - high in SHIFT and DONE
//                done_o     - one-cycle pulse after the final bit
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_gen #(
    parameter int              WIDTH   = 12,
    parameter logic [WIDTH-1:0] PATTERN = 12'hEDB,
    parameter int              CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] pattern_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] reps_i,
    input  logic             stop_i,
    output logic             x_o,
    output logic             valid_o,
    output logic             frame_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int                c_BIT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_BIT_W-1:0] c_LAST  = c_BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state,     w_state;
    logic [WIDTH-1:0]   r_pattern,   w_pattern;
    logic [c_BIT_W-1:0] r_bit_cnt,   w_bit_cnt;
    logic [CNT_W-1:0]   r_rep_cnt,   w_rep_cnt;
    logic               r_stop_pend, w_stop_pend;
    logic               r_x,     w_x;
    logic               r_valid, w_valid;
    logic               r_frame, w_frame;
    logic               r_busy,  w_busy;
    logic               r_done,  w_done;

    // The output registers are loaded with the values for the cycle that
    // follows the edge, so r_bit_cnt always indexes the bit currently on x_o.
    always_comb begin
        w_state     = r_state;
        w_pattern   = r_pattern;
        w_bit_cnt   = r_bit_cnt;
        w_rep_cnt   = r_rep_cnt;
        w_stop_pend = r_stop_pend;
        w_x         = 1'b0;
        w_valid     = 1'b0;
        w_frame     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_stop_pend = 1'b0;
                if (load_i) begin
                    w_pattern = pattern_i;
                end
                if (start_i) begin
                    // w_pattern already carries a same-cycle load
                    w_state   = S_SHIFT;
                    w_rep_cnt = reps_i;
                    w_bit_cnt = '0;
                    w_x       = w_pattern[WIDTH-1];
                    w_valid   = 1'b1;
                    w_frame   = 1'b1;
                    w_busy    = 1'b1;
                end
            end

            S_SHIFT: begin
                w_busy      = 1'b1;
                // A stop seen on the last-bit cycle still ends this instance
                w_stop_pend = r_stop_pend | stop_i;
                if (r_bit_cnt == c_LAST) begin
                    if ((r_rep_cnt == CNT_W'(1)) || w_stop_pend) begin
                        w_state = S_DONE;
                        w_done  = 1'b1;
                    end else begin
                        w_bit_cnt = '0;
                        if (r_rep_cnt != '0) begin
                            w_rep_cnt = r_rep_cnt - CNT_W'(1);
                        end
                        w_x     = r_pattern[WIDTH-1];
                        w_valid = 1'b1;
                        w_frame = 1'b1;
                    end
                end else begin
                    w_bit_cnt = r_bit_cnt + c_BIT_W'(1);
                    w_x       = r_pattern[c_LAST - w_bit_cnt];
                    w_valid   = 1'b1;
                end
            end

            S_DONE: begin
                w_state     = S_IDLE;
                w_stop_pend = 1'b0;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pattern   <= PATTERN;
            r_bit_cnt   <= '0;
            r_rep_cnt   <= '0;
            r_stop_pend <= 1'b0;
            r_x         <= 1'b0;
            r_valid     <= 1'b0;
            r_frame     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_pattern   <= w_pattern;
            r_bit_cnt   <= w_bit_cnt;
            r_rep_cnt   <= w_rep_cnt;
            r_stop_pend <= w_stop_pend;
            r_x         <= w_x;
            r_valid     <= w_valid;
            r_frame     <= w_frame;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

    assign x_o     = r_x;
    assign valid_o = r_valid;
    assign frame_o = r_frame;
    assign busy_o  = r_busy;
    assign done_o  = r_done;

endmodule
`default_nettype wire
